fib_sequencer: RTL



---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_datapath.sv | 38 +++
 rtl/fib_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci job sequencer and its datapath.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FIB_WIDTH = 8;
  localparam int FIB_NW    = 4;

  localparam int A_INIT = 0;
  localparam int B_INIT = 1;

endpackage

// File: rtl/fib_datapath.sv
// Two-register alternating Fibonacci datapath: one shared adder, sel picks the register to overwrite.
// load restarts at fib(0); each step advances one index in one cycle; value = sel ? b : a.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH:0]   sum;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign carry = sum[WIDTH];
  assign value = sel ? b : a;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      a   <= WIDTH'(A_INIT);
      b   <= WIDTH'(B_INIT);
      sel <= 1'b0;
    end else if (step) begin
      // Older operand is overwritten so the pair always holds fib(k-1), fib(k).
      if (sel) b <= sum[WIDTH-1:0];
      else     a <= sum[WIDTH-1:0];
      sel <= ~sel;
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Job controller: accepts index N, runs N datapath steps, returns fib(N); FIB_SEQ_OVF_EN adds rsp_ovf.
// Latency N+1 cycles from request handshake; response held stable under rsp_ready backpressure.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NW    = FIB_NW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NW-1:0]    req_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_ovf,
  output logic             busy
);

  state_t        state;
  state_t        state_nxt;
  logic [NW-1:0] cnt;
  logic          load;
  logic          step;
  logic          carry;
  logic          last_step;

  fib_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .value (rsp_value),
    .carry (carry)
  );

  assign last_step = (cnt == NW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)      cnt <= req_n;
      else if (step) cnt <= cnt - NW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (req_n == '0) ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == DONE);
    busy      = (state == RUN);
    load      = (state == IDLE) && req_valid;
    step      = (state == RUN);
  end

`ifdef FIB_SEQ_OVF_EN
  logic ovf;

  // The final step's sum is fib(N+1), never presented, so its carry is excluded.
  always_ff @(posedge clk) begin
    if (!rst_n || load) ovf <= 1'b0;
    else if (step && carry && !last_step) ovf <= 1'b1;
  end

  assign rsp_ovf = ovf;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign rsp_ovf      = 1'b0;
`endif

endmodule
